// File: rtl/acc_result_collector_l10_pkg.sv
// Shared L10 datapath constants for the result-collection stage.
package acc_result_collector_l10_pkg;

  localparam int unsigned LAT_L10        = 4;
  localparam int unsigned RES_W          = 16;
  localparam int unsigned RES_FIFO_DEPTH = 8;

endpackage

// File: rtl/acc_result_collector_l10_fifo.sv
// Synchronous FIFO with extra-MSB pointers; simultaneous push/pop is accepted even when full.
module sync_fifo_l10
  import acc_result_collector_l10_pkg::*;
#(
  parameter int unsigned DW    = RES_W,
  parameter int unsigned DEPTH = RES_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count   = wr_q - rd_q;
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign pop_ok  = pop & ~empty;
  // A pop frees the slot this edge, so a full FIFO may still take a push.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + (AW+1)'(1);
      if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/acc_result_collector_l10.sv
// Tracks adder-tree latency for pixel-final chunks, captures ReLU results into a FIFO,
// drains them over valid/ready and back-pressures the feeder.
module acc_result_collector_l10
  import acc_result_collector_l10_pkg::*;
#(
  parameter int unsigned LAT   = LAT_L10,
  parameter int unsigned DEPTH = RES_FIFO_DEPTH,
  parameter int unsigned DW    = RES_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     chunk_valid,
  input  logic                     chunk_last,
  input  logic [DW-1:0]            tree_out,
  output logic [DW-1:0]            res_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = $clog2(LAT + 1);
  localparam int unsigned SW = ((CW > IW) ? CW : IW) + 1;

  logic [LAT-1:0] dl_q, dl_d;
  logic [IW-1:0]  inflight;
  logic           overflow_q, overflow_d;
  logic           capture;
  logic           pop;
  logic           full;
  logic           empty;

  assign capture = dl_q[LAT-1];
  assign pop     = res_valid & res_ready;

  always_comb begin
    dl_d       = flush ? '0 : LAT'({dl_q, chunk_valid & chunk_last});
    overflow_d = flush ? 1'b0 : (overflow_q | (capture & full & ~pop));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      dl_q       <= dl_d;
      overflow_q <= overflow_d;
    end
  end

  // Results still travelling through the tree already own a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + IW'(dl_q[i]);
  end

  assign stall     = (SW'(fifo_count) + SW'(inflight)) >= SW'(DEPTH);
  assign res_valid = ~empty;
  assign overflow  = overflow_q;

  sync_fifo_l10 #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (capture),
    .pop   (pop),
    .wdata (tree_out),
    .rdata (res_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule
